// File: rtl/axi4_duth_noc_ni_pkg.sv
// Shared types and helpers for the slave-NI address route scheduler.
//   rr_ptr_e     : round-robin pointer between the AW and AR request channels
//   rt_state_e   : occupancy of the one-entry route output stage
//   lowest_set_idx : one-hot/multi-hot to binary index, lowest set bit wins
// The route_t record is declared inside axi_addr_route_sched, because its
// field widths follow that module's ADDRESS_WIDTH / EXT_SLAVES parameters.
package axi4_duth_noc_ni_pkg;

  // Upper bound on the address-map size that the encoder below can handle.
  localparam int MAX_SLAVES = 32;
  localparam int MAX_ID_W   = 5;

  typedef enum logic {
    PTR_AW = 1'b0,
    PTR_AR = 1'b1
  } rr_ptr_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } rt_state_e;

  // Walks from the top bit down, so the last assignment is made by the lowest
  // set bit. An all-zero vector returns 0.
  function automatic logic [MAX_ID_W-1:0] lowest_set_idx(input logic [MAX_SLAVES-1:0] vec);
    logic [MAX_ID_W-1:0] idx;
    idx = '0;
    for (int i = MAX_SLAVES-1; i >= 0; i--)
      if (vec[i]) idx = MAX_ID_W'(i);
    return idx;
  endfunction

endpackage

// File: rtl/axi_address_lut.sv
// Address-map range lookup.
//   addr : address to decode
//   hit  : hit[i] = 1 when ADDRS_LO[i] <= addr <= ADDRS_HI[i] (unsigned, inclusive)
// Ranges may overlap; resolving several hits is left to the caller.
module axi_address_lut #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int EXT_SLAVES    = 4,
  parameter logic [EXT_SLAVES*ADDRESS_WIDTH-1:0] ADDRS_LO = '0,
  parameter logic [EXT_SLAVES*ADDRESS_WIDTH-1:0] ADDRS_HI = '1
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  output logic [EXT_SLAVES-1:0]    hit
);

  for (genvar i = 0; i < EXT_SLAVES; i++) begin : g_slv
    logic [ADDRESS_WIDTH-1:0] lo_b, hi_b;
    assign lo_b   = ADDRS_LO[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign hi_b   = ADDRS_HI[i*ADDRESS_WIDTH +: ADDRESS_WIDTH];
    assign hit[i] = (addr >= lo_b) && (addr <= hi_b);
  end

endmodule

// File: rtl/axi_addr_route_sched.sv
// Slave-NI front end: the AW and AR channels share a single address lookup.
// A 2-way round-robin picks one channel. Its address is decoded, and the
// resulting route is registered into a one-entry valid/ready output stage.
//   clk, rst                 : clock, async active-high reset
//   aw_valid/aw_ready/aw_addr: write address request
//   ar_valid/ar_ready/ar_addr: read address request
//   rt_valid/rt_ready        : route entry handshake toward the packetizer
//   rt_is_write              : 1 = AW origin, 0 = AR origin
//   rt_slave_id, rt_decerr   : decoded target (lowest matching index) / no match
//   rt_addr                  : address carried with the entry
//   err_cnt                  : saturating count of accepted decode errors
module axi_addr_route_sched
  import axi4_duth_noc_ni_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int EXT_SLAVES    = 4,
  parameter logic [EXT_SLAVES*ADDRESS_WIDTH-1:0] ADDRS_LO = '0,
  parameter logic [EXT_SLAVES*ADDRESS_WIDTH-1:0] ADDRS_HI = '1,
  parameter int ERR_CNT_W     = 8,
  localparam int SLV_ID_W     = (EXT_SLAVES > 1) ? $clog2(EXT_SLAVES) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     aw_valid,
  output logic                     aw_ready,
  input  logic [ADDRESS_WIDTH-1:0] aw_addr,
  input  logic                     ar_valid,
  output logic                     ar_ready,
  input  logic [ADDRESS_WIDTH-1:0] ar_addr,
  output logic                     rt_valid,
  input  logic                     rt_ready,
  output logic                     rt_is_write,
  output logic [SLV_ID_W-1:0]      rt_slave_id,
  output logic                     rt_decerr,
  output logic [ADDRESS_WIDTH-1:0] rt_addr,
  output logic [ERR_CNT_W-1:0]     err_cnt
);

  typedef struct packed {
    logic                     is_write;
    logic [SLV_ID_W-1:0]      slave_id;
    logic                     decerr;
    logic [ADDRESS_WIDTH-1:0] addr;
  } route_t;

  rt_state_e                st_q, st_d;
  rr_ptr_e                  rr_q;
  route_t                   rt_q, rt_d;
  logic                     can_load, grant_aw, grant_ar, grant;
  logic [ADDRESS_WIDTH-1:0] lut_addr;
  logic [EXT_SLAVES-1:0]    hit;

  // The stage can take a new entry when it is empty or is being unloaded
  // this cycle. A full-and-stalled stage therefore blocks both channels.
  assign can_load = (st_q == ST_EMPTY) | rt_ready;

  // The pointer only matters when both channels request; a lone requester
  // always wins.
  assign grant_aw = can_load & aw_valid & (~ar_valid | (rr_q == PTR_AW));
  assign grant_ar = can_load & ar_valid & (~aw_valid | (rr_q == PTR_AR));
  assign grant    = grant_aw | grant_ar;

  // Readys are forced low during reset, because the empty stage would
  // otherwise report can_load=1.
  assign aw_ready = grant_aw & ~rst;
  assign ar_ready = grant_ar & ~rst;

  assign lut_addr = grant_ar ? ar_addr : aw_addr;

  axi_address_lut #(
    .ADDRESS_WIDTH (ADDRESS_WIDTH),
    .EXT_SLAVES    (EXT_SLAVES),
    .ADDRS_LO      (ADDRS_LO),
    .ADDRS_HI      (ADDRS_HI)
  ) u_lut (
    .addr (lut_addr),
    .hit  (hit)
  );

  always_comb begin
    rt_d          = '0;
    rt_d.is_write = grant_aw;
    rt_d.addr     = lut_addr;
    rt_d.decerr   = ~|hit;
    // A zero hit vector encodes to 0, which gives slave_id=0 on a decode error.
    rt_d.slave_id = SLV_ID_W'(lowest_set_idx(MAX_SLAVES'(hit)));
  end

  // Stage occupancy: a load wins over an unload, so a simultaneous
  // unload-and-load stays FULL.
  always_comb begin
    st_d = st_q;
    if (grant)         st_d = ST_FULL;
    else if (rt_ready) st_d = ST_EMPTY;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= ST_EMPTY;
      rr_q    <= PTR_AW;
      rt_q    <= '0;
      err_cnt <= '0;
    end else begin
      st_q <= st_d;
      if (grant) begin
        rt_q <= rt_d;
        rr_q <= (rr_q == PTR_AW) ? PTR_AR : PTR_AW;
        if (rt_d.decerr && (err_cnt != {ERR_CNT_W{1'b1}}))
          err_cnt <= err_cnt + ERR_CNT_W'(1);
      end
    end
  end

  assign rt_valid    = (st_q == ST_FULL);
  assign rt_is_write = rt_q.is_write;
  assign rt_slave_id = rt_q.slave_id;
  assign rt_decerr   = rt_q.decerr;
  assign rt_addr     = rt_q.addr;

endmodule
